// File: rtl/fround_pack.sv
// Rounds an extended-format operand (EW2 exponent, FW2+1 significand) and packs it to an EW1/FW1 word.
// Two-stage valid/ready pipeline; define FROUND_PACK_FLAGS_EN to build the {ovf, unf, inexact, 0} flags.
module fround_pack #(
    parameter int FW1 = 23,
    parameter int FW2 = 40,
    parameter int EW1 = 8,
    parameter int EW2 = 10,
    parameter int TW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EW2-1:0]     exponentA,
    input  logic [FW2:0]       significantA,
    input  logic               signA,
    input  logic               infA,
    input  logic               nanA,
    input  logic               zeroA,
    input  logic [2:0]         rm,
    input  logic [TW-1:0]      tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EW1+FW1:0]   result,
    output logic [TW-1:0]      tag_out,
    output logic [3:0]         flags
);

    localparam int OW = EW1 + FW1 + 1;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [EW2:0] EXP_ALL1 = (EW2+1)'((1 << EW1) - 1);

    function automatic logic round_up(input logic [2:0] mode, input logic s,
                                      input logic lsb, input logic g, input logic st);
        case (mode)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = (g | st) & s;
            RM_RUP:  round_up = (g | st) & ~s;
            RM_RMM:  round_up = g;
            default: round_up = g & (st | lsb);
        endcase
    endfunction

    // Overflow saturates to max-finite when the mode rounds toward zero for this sign.
    function automatic logic [OW-1:0] ovf_value(input logic [2:0] mode, input logic s);
        if (mode == RM_RTZ || (mode == RM_RDN && !s) || (mode == RM_RUP && s))
            ovf_value = {s, {(EW1-1){1'b1}}, 1'b0, {FW1{1'b1}}};
        else
            ovf_value = {s, {EW1{1'b1}}, {FW1{1'b0}}};
    endfunction

    logic               v1_q, v2_q;
    logic               adv;
    logic               s1_q, up1_q, nan1_q, inf1_q, zero1_q;
    logic [FW1:0]       keep1_q;
    logic [EW2-1:0]     exp1_q;
    logic [2:0]         rm1_q;
    logic [TW-1:0]      tag1_q, tag_q;
    logic [OW-1:0]      result_q, res_d;

    logic [FW1:0]       keep_d;
    logic               guard_d, sticky_d, up_d;
    logic [FW1+1:0]     sum;
    logic               carry;
    logic [EW2:0]       exp_rnd;
    logic [FW1-1:0]     frac;
    logic               ovf_d, unf_d, special_d;
    logic               unused_hidden;

    assign adv       = ~v2_q | out_ready;
    assign in_ready  = ~v1_q | adv;
    assign out_valid = v2_q;
    assign result    = result_q;
    assign tag_out   = tag_q;

    // Stage 1: split significand into kept bits, guard and sticky; decide the round-up.
    assign keep_d   = significantA[FW2:FW2-FW1];
    assign guard_d  = significantA[FW2-FW1-1];
    assign sticky_d = |significantA[FW2-FW1-2:0];
    assign up_d     = round_up(rm, signA, keep_d[0], guard_d, sticky_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            up1_q   <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            keep1_q <= '0;
            exp1_q  <= '0;
            rm1_q   <= '0;
            tag1_q  <= '0;
        end else if (in_ready) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_q    <= signA;
                up1_q   <= up_d;
                nan1_q  <= nanA;
                inf1_q  <= infA;
                zero1_q <= zeroA;
                keep1_q <= keep_d;
                exp1_q  <= exponentA;
                rm1_q   <= rm;
                tag1_q  <= tag_in;
            end
        end
    end

    // Stage 2: increment, renormalize on carry, classify and pack.
    always_comb begin
        sum           = {1'b0, keep1_q} + {{(FW1+1){1'b0}}, up1_q};
        carry         = sum[FW1+1];
        unused_hidden = sum[FW1];
        exp_rnd       = {1'b0, exp1_q} + {{EW2{1'b0}}, carry};
        frac          = carry ? '0 : sum[FW1-1:0];
        special_d     = nan1_q | inf1_q | zero1_q;
        ovf_d         = 1'b0;
        unf_d         = 1'b0;
        res_d         = {s1_q, exp_rnd[EW1-1:0], frac};
        if (nan1_q) begin
            res_d = {1'b0, {EW1{1'b1}}, 1'b1, {(FW1-1){1'b0}}};
        end else if (inf1_q) begin
            res_d = {s1_q, {EW1{1'b1}}, {FW1{1'b0}}};
        end else if (zero1_q) begin
            res_d = {s1_q, {(OW-1){1'b0}}};
        end else if (exp1_q == '0) begin
            unf_d = 1'b1;
            res_d = {s1_q, {(OW-1){1'b0}}};
        end else if (exp_rnd >= EXP_ALL1) begin
            ovf_d = 1'b1;
            res_d = ovf_value(rm1_q, s1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q     <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                result_q <= res_d;
                tag_q    <= tag1_q;
            end
        end
    end

`ifdef FROUND_PACK_FLAGS_EN
    logic       inexact1_q;
    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inexact1_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            if (in_ready && in_valid)
                inexact1_q <= guard_d | sticky_d;
            if (adv && v1_q)
                flags_q <= {ovf_d, unf_d, ~special_d & (inexact1_q | ovf_d | unf_d), 1'b0};
        end
    end

    assign flags = flags_q;
`else
    logic unused_flag_terms;
    assign unused_flag_terms = ovf_d ^ unf_d ^ special_d;
    assign flags = '0;
`endif

endmodule

// File: tb/tb_fround_pack.sv
// Scoreboard bench for fround_pack: stimulus pushes reference results, a monitor pops on each output transfer.
module tb_fround_pack;
    localparam int FW1 = 23;
    localparam int FW2 = 40;
    localparam int EW1 = 8;
    localparam int EW2 = 10;
    localparam int TW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [EW2-1:0] exponentA;
    logic [FW2:0]   significantA;
    logic           signA, infA, nanA, zeroA;
    logic [2:0]     rm;
    logic [TW-1:0]  tag_in;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    result;
    logic [TW-1:0]  tag_out;
    logic [3:0]     flags;

    fround_pack #(.FW1(FW1), .FW2(FW2), .EW1(EW1), .EW2(EW2), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .exponentA(exponentA), .significantA(significantA), .signA(signA),
        .infA(infA), .nanA(nanA), .zeroA(zeroA), .rm(rm), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .tag_out(tag_out), .flags(flags)
    );

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  t;
        logic [3:0]  f;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          accepted = 0;
    bit          dir_en = 0;
    logic [31:0] dir_r;
    logic [3:0]  dir_f;
    bit          rand_ready = 0;
    logic        rnd_ready = 1'b1;
    logic        ready_cmd = 1'b1;
    bit          hold_pending = 0;
    logic [31:0] held_r;
    logic [3:0]  held_t;

    assign out_ready = rand_ready ? rnd_ready : ready_cmd;

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom % 4) != 0;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef FROUND_PACK_FLAGS_EN
        return f;
`else
        return 4'h0 & f;
`endif
    endfunction

    // Reference: integer rounding on the dropped remainder compared against one half-ulp.
    function automatic void model(input longint sig, input int expn, input bit s, input bit inf,
                                  input bit nan, input bit zero, input int rmv,
                                  output logic [31:0] r, output logic [3:0] f);
        longint keep, rem, half, k;
        int     e, mode;
        bit     up, inexact, maxf;
        f = 4'h0;
        if (nan) r = 32'h7FC00000;
        else if (inf) r = {s, 8'hFF, 23'h0};
        else if (zero) r = {s, 31'h0};
        else if (expn == 0) begin
            r = {s, 31'h0};
            f = 4'b0110;
        end else begin
            keep = sig >> (FW2 - FW1);
            rem  = sig & ((64'd1 << (FW2 - FW1)) - 1);
            half = 64'd1 << (FW2 - FW1 - 1);
            inexact = (rem != 0);
            mode = (rmv > 4) ? 0 : rmv;
            case (mode)
                0: up = (rem > half) || (rem == half && (keep % 2) == 1);
                1: up = 0;
                2: up = inexact && s;
                3: up = inexact && !s;
                default: up = (rem >= half);
            endcase
            k = keep + (up ? 1 : 0);
            e = expn;
            if (k >= (64'd1 << (FW1 + 1))) begin
                k = k >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                maxf = (mode == 1) || (mode == 2 && !s) || (mode == 3 && s);
                r = maxf ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
                f = 4'b1010;
            end else begin
                r = {s, e[7:0], k[22:0]};
                f = {2'b00, inexact, 1'b0};
            end
        end
        f = fl(f);
    endfunction

    // Input side: record the expected response at every accepted transfer.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && in_valid && in_ready) begin
            if (dir_en) begin
                x.r = dir_r;
                x.f = fl(dir_f);
            end else begin
                model(longint'(significantA), int'(exponentA), signA, infA, nanA, zeroA,
                      int'(rm), x.r, x.f);
            end
            x.t = tag_in;
            sb.push_back(x);
            accepted++;
        end
    end

    // Output side: compare on transfer, check stability while stalled.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (hold_pending) begin
                hold_pending = 0;
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_result", 64'(result), 64'(held_r));
                check("hold_tag", 64'(tag_out), 64'(held_t));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", result);
                end else begin
                    x = sb.pop_front();
                    check("result", 64'(result), 64'(x.r));
                    check("tag", 64'(tag_out), 64'(x.t));
                    check("flags", 64'(flags), 64'(x.f));
                end
            end else if (out_valid && !out_ready) begin
                held_r = result;
                held_t = tag_out;
                hold_pending = 1;
            end
        end
    end

    task automatic send(input longint sig, input int e, input bit s, input bit inf, input bit nan,
                        input bit zero, input int rmv, input logic [3:0] tg);
        int n;
        significantA = sig[FW2:0];
        exponentA    = e[EW2-1:0];
        signA = s; infA = inf; nanA = nan; zeroA = zero;
        rm = rmv[2:0];
        tag_in = tg;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_dir(input longint sig, input int e, input bit s, input bit nan, input int rmv,
                            input logic [3:0] tg, input logic [31:0] er, input logic [3:0] ef);
        dir_en = 1;
        dir_r = er;
        dir_f = ef;
        send(sig, e, s, 1'b0, nan, 1'b0, rmv, tg);
        dir_en = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    localparam longint ONE = 64'h100_0000_0000;

    initial begin
        longint sig;
        int     e, c;
        bit     nan, inf, zero;
        rst_n = 1'b0;
        in_valid = 1'b0;
        significantA = '0; exponentA = '0;
        signA = 0; infA = 0; nanA = 0; zeroA = 0; rm = 3'd0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send_dir(ONE, 127, 0, 0, 0, 4'h5, 32'h3F800000, 4'b0000);
        check("lat_stage1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_stage2", 64'(out_valid), 64'd1);
        drain();

        send_dir(64'h100_0001_0000, 127, 0, 0, 0, 4'h1, 32'h3F800000, 4'b0010);
        send_dir(64'h100_0001_0000, 127, 0, 0, 3, 4'h2, 32'h3F800001, 4'b0010);
        send_dir(64'h1FF_FFFF_FFFF, 127, 0, 0, 0, 4'h3, 32'h40000000, 4'b0010);
        send_dir(ONE, 255, 0, 0, 0, 4'h4, 32'h7F800000, 4'b1010);
        send_dir(ONE, 255, 0, 0, 1, 4'h5, 32'h7F7FFFFF, 4'b1010);
        send_dir(ONE, 255, 1, 0, 2, 4'h6, 32'hFF800000, 4'b1010);
        send_dir(ONE, 255, 1, 0, 3, 4'h7, 32'hFF7FFFFF, 4'b1010);
        send_dir(ONE, 127, 1, 1, 0, 4'h8, 32'h7FC00000, 4'b0000);
        send_dir(ONE, 0, 1, 0, 0, 4'h9, 32'h80000000, 4'b0110);
        send_dir(64'h1FF_FFFF_FFFF, 254, 0, 0, 6, 4'hA, 32'h7F800000, 4'b1010);
        send_dir(64'h100_0001_8000, 127, 0, 0, 4, 4'hB, 32'h3F800001, 4'b0010);
        send_dir(64'h100_0001_0000, 127, 1, 0, 4, 4'hC, 32'hBF800001, 4'b0010);
        drain();

        ready_cmd = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(ONE | (64'(i) << 20), 100 + i, 0, 0, 0, 0, 0, 4'(i));
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_accepted", 64'(accepted), 64'd2);
                @(posedge clk);
                #1 ready_cmd = 1'b1;
            end
        join
        drain();

        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            sig = ONE | ({32'($urandom), 32'($urandom)} & ((64'd1 << FW2) - 1));
            if ($urandom % 5 == 0) sig = (sig & ~((64'd1 << (FW2 - FW1)) - 1)) | (64'd1 << (FW2 - FW1 - 1));
            if ($urandom % 7 == 0) sig = sig | (((64'd1 << FW1) - 1) << (FW2 - FW1));
            c = $urandom % 16;
            e = (c == 0) ? 0 : (c == 1) ? 255 : (c == 2) ? 254 :
                (c == 3) ? int'($urandom_range(256, 1023)) : int'($urandom_range(1, 254));
            c = $urandom % 20;
            nan  = (c == 0);
            inf  = (c == 1) || (c == 0 && ($urandom % 2) == 1);
            zero = (c == 2) || (c <= 1 && ($urandom % 2) == 1);
            send(sig, e, 1'($urandom), inf, nan, zero, int'($urandom % 8), 4'($urandom));
            if ($urandom % 6 == 0) begin
                repeat ($urandom % 3) @(posedge clk);
                #1;
            end
        end
        drain();
        rand_ready = 0;

        ready_cmd = 1'b0;
        send(ONE, 120, 0, 0, 0, 0, 0, 4'hD);
        send(ONE, 121, 1, 0, 0, 0, 0, 4'hE);
        check("inflight_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        hold_pending = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_cmd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send_dir(ONE, 130, 1, 0, 0, 4'hF, 32'hC1000000, 4'b0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
